// File: rtl/dmem_sram_ctrl_pkg.sv
// Shared constants for the data-memory SRAM responder: access sizes, FSM encodings, lane helpers.
package dmem_sram_ctrl_pkg;

  localparam int XLEN_DEF = 32;

  localparam logic [1:0] F3_BYTE = 2'b00;
  localparam logic [1:0] F3_HALF = 2'b01;
  localparam logic [1:0] F3_WORD = 2'b10;
  localparam logic [1:0] F3_RSVD = 2'b11;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_WAIT   = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;
  localparam logic [1:0] ST_RESP   = 2'd3;

  // Byte enables for a 32-bit word; a half at an odd address still uses addr[1] only.
  function automatic logic [3:0] lane_be(input logic [1:0] size, input logic [1:0] a);
    case (size)
      F3_BYTE: lane_be = 4'b0001 << a;
      F3_HALF: lane_be = 4'b0011 << {a[1], 1'b0};
      default: lane_be = 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/dmem_sram_ctrl_if.sv
// CPU<->data-memory request/response bundle; master is the core side, slave the memory side.
interface dmem_sram_ctrl_if #(parameter int XLEN = 32);

  logic [XLEN-1:0] i_DM_Wd;
  logic [XLEN-1:0] i_DM_Addr;
  logic [2:0]      i_DM_f3;
  logic            i_DM_Wen;
  logic            i_DM_MemRead;
  logic            o_DM_data_ready;
  logic [XLEN-1:0] o_DM_ReadData;
  logic            o_bus_err;
  logic            o_busy;

  modport master (
    output i_DM_Wd, i_DM_Addr, i_DM_f3, i_DM_Wen, i_DM_MemRead,
    input  o_DM_data_ready, o_DM_ReadData, o_bus_err, o_busy
  );

  modport slave (
    input  i_DM_Wd, i_DM_Addr, i_DM_f3, i_DM_Wen, i_DM_MemRead,
    output o_DM_data_ready, o_DM_ReadData, o_bus_err, o_busy
  );

endinterface

// File: rtl/dmem_sram_ctrl_bank.sv
// Single-port synchronous word RAM with per-byte write enables and a registered read port.
module dm_sram_bank #(
  parameter int XLEN        = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic                clk,
  input  logic                en,
  input  logic                we,
  input  logic [XLEN/8-1:0]   be,
  input  logic [AW-1:0]       addr,
  input  logic [XLEN-1:0]     wd,
  output logic [XLEN-1:0]     q
);

  logic [XLEN-1:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int i = 0; i < XLEN/8; i++) begin
          if (be[i]) mem[addr][8*i +: 8] <= wd[8*i +: 8];
        end
      end else begin
        q <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/dmem_sram_ctrl.sv
// Data-memory responder: latches one request, inserts wait states, steers byte lanes into the
// SRAM bank and returns right-aligned load data with a one-cycle ready (and error) pulse.
module dmem_sram_ctrl
  import dmem_sram_ctrl_pkg::*;
#(
  parameter int              XLEN        = XLEN_DEF,
  parameter int              DEPTH_WORDS = 1024,
  parameter logic [XLEN-1:0] BASE_ADDR   = '0,
  parameter int              WAIT_STATES = 1
) (
  input  logic            i_clk,
  input  logic            i_rst,
  dmem_sram_ctrl_if.slave dm
);

  localparam int NB = XLEN/8;
  localparam int AW = $clog2(DEPTH_WORDS);

  logic [1:0]      state_q, state_d;
  logic [2:0]      cnt_q, cnt_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] wd_q, wd_d;
  logic [2:0]      f3_q, f3_d;
  logic            wr_q, wr_d;
  logic [XLEN-1:0] rdata_q, rdata_d;

  logic            req;
  logic [XLEN-1:0] off;
  logic            err;
  logic [NB-1:0]   be;
  logic [XLEN-1:0] sdat;
  logic [1:0]      rd_lane;
  logic [XLEN-1:0] bank_q;
  logic [XLEN-1:0] resp_dat;
  logic            unused_ok;

  assign req = dm.i_DM_Wen | dm.i_DM_MemRead;

  // Range check on the latched address; the reserved size also counts as an error.
  assign off = addr_q - BASE_ADDR;
  assign err = (addr_q < BASE_ADDR) || (off[XLEN-1:AW+2] != '0) || (f3_q[1:0] == F3_RSVD);

  assign be = lane_be(f3_q[1:0], addr_q[1:0]);

  always_comb begin
    case (f3_q[1:0])
      F3_BYTE: sdat = {NB{wd_q[7:0]}};
      F3_HALF: sdat = {(NB/2){wd_q[15:0]}};
      default: sdat = wd_q;
    endcase
  end

  dm_sram_bank #(
    .XLEN        (XLEN),
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_bank (
    .clk  (i_clk),
    .en   ((state_q == ST_ACCESS) && !err),
    .we   (wr_q),
    .be   (be),
    .addr (off[AW+1:2]),
    .wd   (sdat),
    .q    (bank_q)
  );

  // Word loads ignore the low address bits; narrower loads are shifted down to bit 0.
  assign rd_lane = (f3_q[1:0] == F3_WORD) ? 2'b00 : addr_q[1:0];

  always_comb begin
    if (err)       resp_dat = '0;
    else if (wr_q) resp_dat = rdata_q;
    else           resp_dat = bank_q >> {rd_lane, 3'b000};
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wd_d    = wd_q;
    f3_d    = f3_q;
    wr_d    = wr_q;
    rdata_d = rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          addr_d  = dm.i_DM_Addr;
          wd_d    = dm.i_DM_Wd;
          f3_d    = dm.i_DM_f3;
          wr_d    = dm.i_DM_Wen;
          cnt_d   = 3'(WAIT_STATES);
          state_d = (WAIT_STATES > 0) ? ST_WAIT : ST_ACCESS;
        end
      end
      ST_WAIT: begin
        // Upstream dropping both enables means a flush: abandon without touching memory.
        if (!req) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 3'd1;
          if (cnt_q == 3'd1) state_d = ST_ACCESS;
        end
      end
      ST_ACCESS: state_d = ST_RESP;
      ST_RESP: begin
        rdata_d = resp_dat;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wd_q    <= '0;
      f3_q    <= '0;
      wr_q    <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wd_q    <= wd_d;
      f3_q    <= f3_d;
      wr_q    <= wr_d;
      rdata_q <= rdata_d;
    end
  end

  assign dm.o_DM_data_ready = (state_q == ST_RESP);
  assign dm.o_bus_err       = (state_q == ST_RESP) && err;
  assign dm.o_busy          = (state_q != ST_IDLE);
  assign dm.o_DM_ReadData   = (state_q == ST_RESP) ? resp_dat : rdata_q;

  assign unused_ok = ^{f3_q[2], off[1:0]};

endmodule

// File: tb/tb_dmem_sram_ctrl.sv
// Directed bench for dmem_sram_ctrl: one instance with 1 wait state, one with 3.
module tb_dmem_sram_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dmem_sram_ctrl_if #(.XLEN(32)) if1 ();
  dmem_sram_ctrl_if #(.XLEN(32)) if3 ();

  dmem_sram_ctrl #(.XLEN(32), .DEPTH_WORDS(1024), .BASE_ADDR(32'h0), .WAIT_STATES(1))
    u_dut1 (.i_clk(clk), .i_rst(rst), .dm(if1));
  dmem_sram_ctrl #(.XLEN(32), .DEPTH_WORDS(1024), .BASE_ADDR(32'h0), .WAIT_STATES(3))
    u_dut3 (.i_clk(clk), .i_rst(rst), .dm(if3));

  int          sel = 1;
  logic        wen = 1'b0, ren = 1'b0;
  logic [2:0]  f3 = 3'b010;
  logic [31:0] addr = '0, wd = '0;

  assign if1.i_DM_Wen     = (sel == 1) && wen;
  assign if1.i_DM_MemRead = (sel == 1) && ren;
  assign if1.i_DM_f3      = f3;
  assign if1.i_DM_Addr    = addr;
  assign if1.i_DM_Wd      = wd;
  assign if3.i_DM_Wen     = (sel == 3) && wen;
  assign if3.i_DM_MemRead = (sel == 3) && ren;
  assign if3.i_DM_f3      = f3;
  assign if3.i_DM_Addr    = addr;
  assign if3.i_DM_Wd      = wd;

  logic        rdy, berr, busy;
  logic [31:0] rdat;
  assign rdy  = (sel == 3) ? if3.o_DM_data_ready : if1.o_DM_data_ready;
  assign berr = (sel == 3) ? if3.o_bus_err       : if1.o_bus_err;
  assign busy = (sel == 3) ? if3.o_busy          : if1.o_busy;
  assign rdat = (sel == 3) ? if3.o_DM_ReadData   : if1.o_DM_ReadData;

  int passed = 0;
  int total  = 0;

  // Ready must never be high on two consecutive cycles, on either instance.
  int   viol = 0;
  logic p1 = 1'b0, p3 = 1'b0;
  always @(negedge clk) begin
    if ((if1.o_DM_data_ready && p1) || (if3.o_DM_data_ready && p3)) viol <= viol + 1;
    p1 <= if1.o_DM_data_ready;
    p3 <= if3.o_DM_data_ready;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // One transaction; latency counts clock edges from the cycle the request is presented.
  task automatic run(input string tag, input bit w, input logic [2:0] f, input logic [31:0] a,
                     input logic [31:0] d, input int exp_lat, input bit chk_rd,
                     input logic [31:0] exp_rd, input logic exp_err, input bit no_wait);
    int          lat;
    logic [31:0] rd;
    logic        e;
    @(negedge clk);
    wen = w; ren = !w; f3 = f; addr = a; wd = d;
    lat = -1; rd = 'x; e = 1'bx;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (rdy) begin
        lat = i; rd = rdat; e = berr;
        break;
      end
    end
    wen = 1'b0; ren = 1'b0;
    chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_err"}, {31'b0, e}, {31'b0, exp_err});
    if (chk_rd) chk({tag, "_rd"}, rd, exp_rd);
    if (!no_wait) @(posedge clk);
  endtask

  initial begin
    int seen;
    rst = 1'b0;
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", {31'b0, rdy}, 32'd0);
    chk("rst_err",   {31'b0, berr}, 32'd0);
    chk("rst_busy",  {31'b0, busy}, 32'd0);
    chk("rst_rdata", rdat, 32'd0);
    @(negedge clk) rst = 1'b0;

    // Instance with one wait state.
    sel = 1;
    run("wr_word",   1, 3'b010, 32'h10, 32'hDEADBEEF, 3, 0, 32'h0, 1'b0, 0);
    run("rd_word",   0, 3'b010, 32'h10, 32'h0,        3, 1, 32'hDEADBEEF, 1'b0, 0);
    run("wr_base",   1, 3'b010, 32'h10, 32'h11223344, 3, 0, 32'h0, 1'b0, 0);
    run("wr_byte",   1, 3'b000, 32'h13, 32'h000000A5, 3, 0, 32'h0, 1'b0, 0);
    run("rd_merged", 0, 3'b010, 32'h10, 32'h0,        3, 1, 32'hA5223344, 1'b0, 0);
    run("rd_byte",   0, 3'b000, 32'h13, 32'h0,        3, 1, 32'h000000A5, 1'b0, 0);
    run("wr_zero",   1, 3'b010, 32'h14, 32'h0,        3, 0, 32'h0, 1'b0, 0);
    run("wr_half",   1, 3'b001, 32'h16, 32'h0000CAFE, 3, 0, 32'h0, 1'b0, 0);
    run("rd_hword",  0, 3'b010, 32'h14, 32'h0,        3, 1, 32'hCAFE0000, 1'b0, 0);
    run("rd_half",   0, 3'b001, 32'h16, 32'h0,        3, 1, 32'h0000CAFE, 1'b0, 0);
    run("rd_oor",    0, 3'b010, 32'h1000, 32'h0,      3, 1, 32'h0, 1'b1, 0);
    run("wr_rsvd",   1, 3'b011, 32'h14, 32'hFFFFFFFF, 3, 1, 32'h0, 1'b1, 0);
    run("rd_after_rsvd", 0, 3'b010, 32'h14, 32'h0,    3, 1, 32'hCAFE0000, 1'b0, 0);

    // Instance with three wait states.
    sel = 3;
    run("w3_wr",  1, 3'b010, 32'h20, 32'h12345678, 5, 0, 32'h0, 1'b0, 0);
    @(negedge clk);
    wen = 1'b1; f3 = 3'b010; addr = 32'h20; wd = 32'hFFFFFFFF;
    @(posedge clk); @(posedge clk); @(negedge clk);
    wen = 1'b0;
    seen = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (rdy) seen = 1;
    end
    chk("abort_no_ready", 32'(seen), 32'd0);
    chk("abort_idle", {31'b0, busy}, 32'd0);
    run("abort_mem", 0, 3'b010, 32'h20, 32'h0, 5, 1, 32'h12345678, 1'b0, 0);
    run("w3_wr24", 1, 3'b010, 32'h24, 32'h0BADF00D, 5, 0, 32'h0, 1'b0, 0);
    run("b2b_a",   0, 3'b010, 32'h20, 32'h0, 5, 1, 32'h12345678, 1'b0, 1);
    run("b2b_b",   0, 3'b010, 32'h24, 32'h0, 6, 1, 32'h0BADF00D, 1'b0, 0);

    // Reset while a write is waiting.
    @(negedge clk);
    wen = 1'b1; f3 = 3'b010; addr = 32'h24; wd = 32'h55555555;
    @(posedge clk); #1;
    chk("rstw_busy_before", {31'b0, busy}, 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("rstw_ready", {31'b0, rdy}, 32'd0);
    chk("rstw_busy",  {31'b0, busy}, 32'd0);
    chk("rstw_rdata", rdat, 32'd0);
    @(negedge clk);
    wen = 1'b0; rst = 1'b0;
    run("rstw_mem", 0, 3'b010, 32'h24, 32'h0, 5, 1, 32'h0BADF00D, 1'b0, 0);

    // Reset while the response is on the bus.
    sel = 1;
    @(negedge clk);
    ren = 1'b1; f3 = 3'b010; addr = 32'h10;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (rdy) begin
        seen = 1;
        break;
      end
    end
    chk("rstr_seen",  32'(seen), 32'd1);
    chk("rstr_data",  rdat, 32'hA5223344);
    #1 rst = 1'b1;
    #1;
    chk("rstr_ready", {31'b0, rdy}, 32'd0);
    chk("rstr_rdata", rdat, 32'd0);
    @(negedge clk);
    ren = 1'b0; rst = 1'b0;
    repeat (2) @(posedge clk);

    chk("no_back_to_back", 32'(viol), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
